// File: rtl/spmm_out_buffer_pkg.sv
// Shared SpMM definitions: default dimensions, element type and the
// output-buffer state encoding.
package spmm_pkg;

    localparam int unsigned N   = 16;
    localparam int unsigned W   = 8;
    localparam int unsigned lgN = $clog2(N);

    typedef logic [W-1:0] data_t;

    typedef enum logic [1:0] {
        COLLECT,
        READY,
        DRAIN
    } state_t;

endpackage

// File: rtl/spmm_out_buffer_if.sv
// Row-write and tile-drain handshake between the PE datapath, the output
// buffer and the SpMM top-level output port.
interface spmm_out_buffer_if import spmm_pkg::*; #(
    parameter int unsigned N = spmm_pkg::N,
    parameter int unsigned W = spmm_pkg::W
);
    localparam int unsigned LGN = $clog2(N);

    logic                         row_valid;
    logic [LGN-1:0]               row_idx;
    logic                         row_os;
    logic [N-1:0][W-1:0]          row_data;
    logic                         row_ready;
    logic                         out_ready;
    logic                         out_start;
    logic                         out_valid;
    logic [3:0][N-1:0][W-1:0]     out_data;
    logic                         drop_err;

    modport master (
        output row_valid, row_idx, row_os, row_data, out_start,
        input  row_ready, out_ready, out_valid, out_data, drop_err
    );

    modport slave (
        input  row_valid, row_idx, row_os, row_data, out_start,
        output row_ready, out_ready, out_valid, out_data, drop_err
    );

endinterface

// File: rtl/spmm_row_acc.sv
// Combinational N-lane row update: overwrite, or add onto the stored row
// with modulo-2^W wrap for output-stationary accumulation.
module spmm_row_acc import spmm_pkg::*; #(
    parameter int unsigned N = spmm_pkg::N,
    parameter int unsigned W = spmm_pkg::W
) (
    input  logic                os,
    input  logic [N-1:0][W-1:0] old_row,
    input  logic [N-1:0][W-1:0] new_row,
    output logic [N-1:0][W-1:0] sum_row
);

    always_comb begin
        sum_row = '0;
        for (int unsigned i = 0; i < N; i++) begin
            sum_row[i] = os ? old_row[i] + new_row[i] : new_row[i];
        end
    end

endmodule

// File: rtl/spmm_out_buffer.sv
// Output staging buffer: collects N result rows (optionally accumulating),
// then drains the tile four rows per beat on request.
module spmm_out_buffer import spmm_pkg::*; #(
    parameter int unsigned N = spmm_pkg::N,
    parameter int unsigned W = spmm_pkg::W
) (
    input  logic              clock,
    input  logic              reset,
    spmm_out_buffer_if.slave  bus
);

    localparam int unsigned LGN = $clog2(N);
    localparam int unsigned NB  = N / 4;
    localparam int unsigned BW  = (LGN > 2) ? LGN - 2 : 1;

    state_t                        state;
    logic [LGN:0]                  cnt;
    logic [BW-1:0]                 b;
    logic [N-1:0][N-1:0][W-1:0]    row_buf;
    logic                          drop_q;
    logic [N-1:0][W-1:0]           acc_row;

    spmm_row_acc #(
        .N (N),
        .W (W)
    ) u_row_acc (
        .os      (bus.row_os),
        .old_row (row_buf[bus.row_idx]),
        .new_row (bus.row_data),
        .sum_row (acc_row)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= COLLECT;
            cnt     <= '0;
            b       <= '0;
            row_buf <= '0;
            drop_q  <= 1'b0;
        end else begin
            unique case (state)
                COLLECT: begin
                    if (bus.row_valid) begin
                        row_buf[bus.row_idx] <= acc_row;
                        cnt                  <= cnt + 1'b1;
                        if (cnt == (LGN+1)'(N - 1)) begin
                            state <= READY;
                        end
                    end
                end
                READY: begin
                    if (bus.row_valid) begin
                        drop_q <= 1'b1;
                    end
                    if (bus.out_start) begin
                        state <= DRAIN;
                        b     <= '0;
                    end
                end
                DRAIN: begin
                    if (bus.row_valid) begin
                        drop_q <= 1'b1;
                    end
                    // Buffer contents are kept after the drain so the next
                    // tile can accumulate onto them.
                    if (b == BW'(NB - 1)) begin
                        state <= COLLECT;
                        cnt   <= '0;
                        b     <= '0;
                    end else begin
                        b <= b + 1'b1;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

    assign bus.row_ready = (state == COLLECT);
    assign bus.out_ready = (state == READY);
    assign bus.out_valid = (state == DRAIN);
    assign bus.drop_err  = drop_q;

    always_comb begin
        bus.out_data = '0;
        if (state == DRAIN) begin
            for (int unsigned k = 0; k < 4; k++) begin
                bus.out_data[k] = row_buf[LGN'({b, 2'(k)})];
            end
        end
    end

endmodule

// File: tb/tb_spmm_out_buffer.sv
// Self-checking bench for spmm_out_buffer: table-driven fill/drain vectors,
// hand-written corner sequences, and a beat scoreboard.
module tb_spmm_out_buffer;

    localparam int unsigned N = 16;
    localparam int unsigned W = 8;

    typedef logic [3:0][N-1:0][W-1:0] beat_t;

    typedef struct {
        logic [W-1:0] fill;
        logic         os;
        logic [W-1:0] exp;
    } vec_t;

    logic clock;
    logic reset;

    spmm_out_buffer_if #(.N(N), .W(W)) bus ();

    spmm_out_buffer #(.N(N), .W(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    int unsigned checks   = 0;
    int unsigned failures = 0;
    beat_t       sb[$];
    logic [N-1:0][N-1:0][W-1:0] exp_tile;
    vec_t        vecs[7];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Beat checker: every valid beat is matched against the scoreboard;
    // idle cycles must show all-zero data.
    always @(negedge clock) begin
        beat_t e;
        checks++;
        if (bus.out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_beat: got %h expected no beat", bus.out_data);
            end else begin
                e = sb.pop_front();
                if (bus.out_data !== e) begin
                    failures++;
                    $display("FAIL beat_data: got %h expected %h", bus.out_data, e);
                end
            end
        end else if (bus.out_data !== '0) begin
            failures++;
            $display("FAIL idle_data_zero: got %h expected 0", bus.out_data);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic write_row(input int unsigned idx, input logic [W-1:0] val, input logic os);
        bus.row_valid = 1'b1;
        bus.row_idx   = 4'(idx);
        bus.row_os    = os;
        bus.row_data  = {N{val}};
        tick();
        bus.row_valid = 1'b0;
    endtask

    task automatic fill_uniform(input logic [W-1:0] val, input logic os);
        for (int unsigned i = 0; i < N; i++) begin
            if (i == N - 1) check("ready_before_last_write", 32'(bus.out_ready), 32'd0);
            write_row(i, val, os);
        end
        check("out_ready_after_fill", 32'(bus.out_ready), 32'd1);
        check("row_ready_after_fill", 32'(bus.row_ready), 32'd0);
    endtask

    task automatic push_beats(input int unsigned nbeats);
        beat_t e;
        for (int unsigned bb = 0; bb < nbeats; bb++) begin
            for (int unsigned k = 0; k < 4; k++) e[k] = exp_tile[4*bb + k];
            sb.push_back(e);
        end
    endtask

    task automatic drain(input logic mid_drop);
        push_beats(4);
        check("out_ready_before_start", 32'(bus.out_ready), 32'd1);
        bus.out_start = 1'b1;
        tick();
        bus.out_start = 1'b0;
        check("out_ready_in_drain", 32'(bus.out_ready), 32'd0);
        check("out_valid_beat0", 32'(bus.out_valid), 32'd1);
        if (mid_drop) begin
            bus.row_valid = 1'b1;
            bus.row_idx   = 4'd12;
            bus.row_os    = 1'b0;
            bus.row_data  = {N{8'hEE}};
        end
        tick();
        bus.row_valid = 1'b0;
        tick();
        tick();
        check("out_valid_beat3", 32'(bus.out_valid), 32'd1);
        tick();
        check("row_ready_after_drain", 32'(bus.row_ready), 32'd1);
        check("out_valid_after_drain", 32'(bus.out_valid), 32'd0);
        check("all_beats_seen", sb.size(), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        reset         = 1'b1;
        bus.row_valid = 1'b0;
        bus.row_idx   = '0;
        bus.row_os    = 1'b0;
        bus.row_data  = '0;
        bus.out_start = 1'b0;

        vecs[0] = '{fill: 8'd200, os: 1'b0, exp: 8'd200};
        vecs[1] = '{fill: 8'd100, os: 1'b1, exp: 8'd44};
        vecs[2] = '{fill: 8'd1,   os: 1'b1, exp: 8'd45};
        vecs[3] = '{fill: 8'd255, os: 1'b0, exp: 8'd255};
        vecs[4] = '{fill: 8'd2,   os: 1'b1, exp: 8'd1};
        vecs[5] = '{fill: 8'd0,   os: 1'b1, exp: 8'd1};
        vecs[6] = '{fill: 8'd128, os: 1'b1, exp: 8'd129};

        tick();
        check("reset_row_ready", 32'(bus.row_ready), 32'd1);
        check("reset_out_ready", 32'(bus.out_ready), 32'd0);
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_drop_err",  32'(bus.drop_err),  32'd0);
        reset = 1'b0;
        tick();

        // Row i holds value i everywhere.
        for (int unsigned i = 0; i < N; i++) begin
            if (i == N - 1) check("ready_before_last_write", 32'(bus.out_ready), 32'd0);
            write_row(i, 8'(i), 1'b0);
            exp_tile[i] = {N{8'(i)}};
        end
        check("out_ready_after_idx_fill", 32'(bus.out_ready), 32'd1);
        check("row_ready_after_idx_fill", 32'(bus.row_ready), 32'd0);
        drain(1'b0);

        do_reset();
        for (int unsigned v = 0; v < 7; v++) begin
            fill_uniform(vecs[v].fill, vecs[v].os);
            exp_tile = {N*N{vecs[v].exp}};
            drain(1'b0);
        end

        // Rows offered in READY and mid-DRAIN must be dropped.
        fill_uniform(8'd10, 1'b0);
        write_row(0, 8'd99, 1'b0);
        check("drop_err_ready", 32'(bus.drop_err), 32'd1);
        check("still_ready_after_drop", 32'(bus.out_ready), 32'd1);
        exp_tile = {N*N{8'd10}};
        drain(1'b1);
        check("drop_err_sticky", 32'(bus.drop_err), 32'd1);

        // out_start during COLLECT is ignored and collection continues.
        for (int unsigned i = 0; i < 5; i++) write_row(i, 8'd20, 1'b0);
        bus.out_start = 1'b1;
        tick();
        bus.out_start = 1'b0;
        check("start_in_collect_valid", 32'(bus.out_valid), 32'd0);
        check("start_in_collect_row_ready", 32'(bus.row_ready), 32'd1);
        for (int unsigned i = 5; i < N; i++) begin
            if (i == N - 1) check("ready_before_last_write", 32'(bus.out_ready), 32'd0);
            write_row(i, 8'd20, 1'b0);
        end
        check("out_ready_after_start_ignored", 32'(bus.out_ready), 32'd1);
        exp_tile = {N*N{8'd20}};
        check("drop_err_still_set", 32'(bus.drop_err), 32'd1);

        // Reset during beat 2 of a drain.
        push_beats(2);
        bus.out_start = 1'b1;
        tick();
        bus.out_start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("reset_mid_drain_valid", 32'(bus.out_valid), 32'd0);
        check("reset_mid_drain_row_ready", 32'(bus.row_ready), 32'd1);
        check("reset_mid_drain_out_ready", 32'(bus.out_ready), 32'd0);
        check("reset_mid_drain_data_zero", 32'(bus.out_data == '0), 32'd1);
        check("reset_mid_drain_drop_err", 32'(bus.drop_err), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        check("reset_mid_drain_no_more_beats", sb.size(), 32'd0);
        fill_uniform(8'd7, 1'b1);
        exp_tile = {N*N{8'd7}};
        drain(1'b0);

        // Back-to-back accumulation on row 3; row 15 keeps its old value.
        write_row(3, 8'd5, 1'b0);
        write_row(3, 8'd6, 1'b1);
        for (int unsigned i = 0; i < 15; i++) begin
            if (i != 3) write_row(i, 8'(50 + i), 1'b0);
        end
        check("out_ready_after_row3_fill", 32'(bus.out_ready), 32'd1);
        for (int unsigned i = 0; i < N; i++) exp_tile[i] = {N{8'(50 + i)}};
        exp_tile[3]  = {N{8'd11}};
        exp_tile[15] = {N{8'd7}};
        drain(1'b0);

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spmm_out_buffer.md
# spmm_out_buffer

Output-side staging buffer for the SpMM engine. Collects the N result rows produced by the PE/reduction datapath, one row per write, optionally accumulating onto the previous tile's contents for output-stationary operation. When all N rows are in, it raises `out_ready` and, on `out_start`, drains the tile onto the 4-row-wide `out_data` port over N/4 beats. It sits directly downstream of the PE array and drives the SpMM top-level output handshake.

## Interface
Parameters:
- `N`, 16: matrix dimension; power of two, ≥ 4.
- `W`, 8: element width in bits; `data_t` is `W` bits.
- `lgN`, `$clog2(N)`: row-index width.

Ports:
- `clock`  in  1: single clock; all state is on its rising edge.
- `reset`  in  1: asynchronous, active-high.
- `row_valid`  in  1: a result row is presented this cycle.
- `row_idx`  in  lgN: destination row of the presented row.
- `row_os`  in  1: 1 = add to the stored row; 0 = overwrite it.
- `row_data`  in  data_t[N]: row elements.
- `row_ready`  out  1: buffer accepts rows (state COLLECT).
- `out_ready`  out  1: full tile held and waiting for drain (state READY).
- `out_start`  in  1: drain request.
- `out_valid`  out  1: `out_data` carries a beat.
- `out_data`  out  data_t[4][N]: rows 4b..4b+3 for beat b.
- `drop_err`  out  1: sticky; a `row_valid` arrived while `row_ready` = 0.

## Operation
- States: COLLECT, READY, DRAIN. Row counter `cnt` (lgN+1 bits). Beat counter `b` (lgN−2 bits, minimum 1 bit).
- COLLECT: on `row_valid`, `buf[row_idx]` is set to `row_os ? buf[row_idx] + row_data : row_data`, elementwise, truncated mod 2^W. `cnt` increments. The write that brings `cnt` to N moves the block to READY. Repeated `row_idx` values are not checked; every write counts toward N.
- READY: holds. `out_start` moves the block to DRAIN with `b` = 0. `row_valid` is dropped and sets `drop_err`.
- DRAIN: `out_valid` = 1. `out_data[k]` = `buf[4b+k]` for k = 0..3. `b` increments each cycle. After beat N/4−1 the block returns to COLLECT with `cnt` = 0. `buf` is retained for later `row_os` accumulation. `row_valid` is dropped and sets `drop_err`. `out_start` is ignored.
- `out_start` outside READY is ignored.
- `out_data` is all-zero whenever `out_valid` = 0.
- `drop_err` clears only on reset.

## Timing
- Reset (asynchronous, any state including mid-DRAIN): state = COLLECT, `cnt` = 0, `b` = 0, every `buf` entry = 0, `drop_err` = 0.
  - Output values under reset: `row_ready` = 1, `out_ready` = 0, `out_valid` = 0, `out_data` = 0.
  - A drain in progress is aborted with no further beats.
- A row written at edge e is visible in `buf` from cycle e+1. A same-row write at edge e+1 accumulates onto that value (back-to-back accumulation to the same row is legal).
- If the N-th write lands at edge e, then `out_ready` = 1 and `row_ready` = 0 from cycle e+1.
- If `out_start` is sampled high at edge t in READY:
  - `out_ready` = 0 from cycle t+1.
  - Beats 0..N/4−1 appear in cycles t+1..t+N/4, with `out_valid` = 1 and no gaps.
  - `row_ready` = 1 again from cycle t+N/4+1.
- `out_data` is a combinational read of `buf` indexed by registered `b` and qualified by state. There is no extra latency.
- `row_ready` and `out_ready` are decoded from state only. They have no combinational path from inputs.

## Structure
- Shared package `spmm_pkg`: `N`, `W`, `lgN`, `data_t`, and the state enum.
- One sub-module, `spmm_row_acc`: combinational N-lane row update computing `os ? old + new : new` with mod-2^W wrap. It is instantiated once on the write port.
- The buffer is an N×N `data_t` register array with asynchronous clear.

## Test plan
N = 16, W = 8.
- Reset, then 16 writes of row i with all elements = i, `row_os` = 0 → `out_ready` rises the cycle after the 16th write. `out_start` → 4 beats; beat 1 shows rows 4..7 with values 4..7; `row_ready` = 1 in the cycle after beat 3.
- Fill with all 200, drain, then refill with all 100 and `row_os` = 1 → second drain shows 44 in every element (300 mod 256).
- `row_valid` asserted in READY and again mid-DRAIN → rows are not written, `drop_err` = 1 and stays 1; drained data is unchanged.
- Assert `out_start` during COLLECT (cnt = 5) → ignored; `out_valid` stays 0 and collection continues to 16.
- Assert reset on DRAIN beat 2 → `out_valid` = 0 immediately; `row_ready` = 1; a subsequent `row_os` = 1 fill of value 7 drains as 7 everywhere, confirming the buffer was cleared.
- Two consecutive writes to row 3: value 5 with `row_os` = 0, then value 6 with `row_os` = 1, plus 14 other rows → row 3 drains as 11.
